sr_drive_ctrl: RTL

//  Upstream driver for the pulse-triggered master-slave SR flip-flop. Turns two raw push-button

---
 rtl/sr_drive_ctrl_if.sv | 23 ++
 rtl/sr_drive_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/sr_drive_ctrl_if.sv
// Button, feedback and status bundle between board-side logic and sr_drive_ctrl.
// The master modport drives the buttons and Q feedback. The slave modport is the controller.
interface sr_drive_ctrl_if;
   logic btn_set;
   logic btn_clr;
   logic q_fb;
   logic S;
   logic R;
   logic busy;
   logic conflict;
   logic dropped;
   logic fault;

   modport master (
      output btn_set, btn_clr, q_fb,
      input  S, R, busy, conflict, dropped, fault
   );

   modport slave (
      input  btn_set, btn_clr, q_fb,
      output S, R, busy, conflict, dropped, fault
   );
endinterface

// File: rtl/sr_drive_ctrl.sv
// Debounced set/clear buttons -> exclusive S/R pulses for an MS SR flip-flop, with a Q check afterwards.
// Press to S/R rise takes DEBOUNCE_CYCLES+3 edges. Requests arriving while busy are dropped, never queued.
module sr_drive_ctrl #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int HOLD_CYCLES     = 1
) (
   input  logic          clk,
   input  logic          rst,
   sr_drive_ctrl_if.slave bus
);

   localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_END = HW'(HOLD_CYCLES);

   typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

   // index 0 = set, index 1 = clear
   logic [1:0]    btn_raw;
   logic [1:0]    meta_q;
   logic [1:0]    sync_q;
   logic [1:0]    deb_q;
   logic [1:0]    req_q;
   logic [CW-1:0] cnt_q [2];

   state_t        state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          exp_q, exp_d;
   logic          fault_q, fault_d;
   logic          conflict_q, conflict_d;
   logic          dropped_q, dropped_d;
   logic          s_q, r_q;
   logic          any_req;
   logic          drive_on;

   assign btn_raw = {bus.btn_clr, bus.btn_set};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
         deb_q  <= '0;
         req_q  <= '0;
         for (int i = 0; i < 2; i++) cnt_q[i] <= '0;
      end else begin
         meta_q <= btn_raw;
         sync_q <= meta_q;
         for (int i = 0; i < 2; i++) begin
            req_q[i] <= 1'b0;
            if (sync_q[i] == deb_q[i]) begin
               cnt_q[i] <= '0;
            end else if (cnt_q[i] == CNT_LAST) begin
               // level accepted; only a rising level becomes a request
               cnt_q[i] <= '0;
               deb_q[i] <= sync_q[i];
               req_q[i] <= sync_q[i];
            end else begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
      end
   end

   assign any_req = req_q[0] | req_q[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         hold_q     <= '0;
         exp_q      <= 1'b0;
         fault_q    <= 1'b0;
         conflict_q <= 1'b0;
         dropped_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_q     <= hold_d;
         exp_q      <= exp_d;
         fault_q    <= fault_d;
         conflict_q <= conflict_d;
         dropped_q  <= dropped_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      exp_d      = exp_q;
      fault_d    = fault_q;
      conflict_d = 1'b0;
      dropped_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_q[0] && req_q[1]) begin
               conflict_d = 1'b1;
            end else if (any_req) begin
               state_d = DRIVE;
               hold_d  = '0;
               exp_d   = req_q[0];
            end
         end
         DRIVE: begin
            dropped_d = any_req;
            if (hold_q == HOLD_END) state_d = CHECK;
            else                    hold_d  = hold_q + 1'b1;
         end
         CHECK: begin
            dropped_d = any_req;
            if (bus.q_fb != exp_q) fault_d = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Launched on the falling edge so S/R are settled across each whole clk-high phase they cover.
   assign drive_on = (state_q == DRIVE) && (hold_q < HOLD_END);

   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         s_q <= 1'b0;
         r_q <= 1'b0;
      end else begin
         s_q <= drive_on &&  exp_q;
         r_q <= drive_on && !exp_q;
      end
   end

   assign bus.S        = s_q;
   assign bus.R        = r_q;
   assign bus.busy     = (state_q != IDLE);
   assign bus.conflict = conflict_q;
   assign bus.dropped  = dropped_q;
   assign bus.fault    = fault_q;

endmodule
